mac_seq_ctrl: RTL
=================

# mac_seq_ctrl

Sequencer for the SRAM/multiplier/adder multiply-accumulate datapath. On a start pulse it:

- loads the coefficient register and clears the accumulator;
- walks `len` consecutive SRAM words, multiplying each by the coefficient and accumulating the product;
- writes the final sum back to SRAM.

It drives only control and address lines. It sits between the top-level command source and the datapath.

## Interface

Parameters:
- `ADDR_WIDTH`, 4, SRAM address width
- `DEPTH`, 16, SRAM word count (`2**ADDR_WIDTH`)

Ports:
- `clk`  in  1  rising-edge clock, single clock domain
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE
- `len`  in  ADDR_WIDTH+1  element count, 0..DEPTH; captured at start
- `base_addr`  in  ADDR_WIDTH  first read address; captured at start
- `dest_addr`  in  ADDR_WIDTH  write-back address; captured at start
- `busy`  out  1  high in every non-IDLE state
- `done`  out  1  one-cycle completion pulse
- `chip_en`  out  1  SRAM chip enable
- `ren`  out  1  SRAM read enable
- `wen`  out  1  SRAM write enable
- `raddr`  out  ADDR_WIDTH  SRAM read address
- `waddr`  out  ADDR_WIDTH  SRAM write address
- `ld_coef`  out  1  load coefficient register
- `clr_acc`  out  1  synchronous clear of accumulator register
- `ld_prod`  out  1  load product register (multiplier output)
- `ld_acc`  out  1  load accumulator register (adder output)

## Operation

- States: IDLE, CLEAR, RD, MUL, ACC, WR, DONE. State, element counter, captured `len`/`base`/`dest` and address pointer are registered.
- Outputs are Moore-decoded from state and pointer.

State behaviour:
- **IDLE:** all outputs 0. If `start`=1, capture inputs and go to CLEAR.
- **CLEAR:** `ld_coef`=1, `clr_acc`=1, counter := 0, pointer := `base`.
  - Captured len=0 → DONE. No SRAM access and no write-back.
  - Otherwise → RD.
- **RD:** `chip_en`=1, `ren`=1, `raddr`=pointer → MUL.
  - SRAM read is synchronous: `dout` is valid in the following cycle.
- **MUL:** `ld_prod`=1; product of `dout` and coefficient is latched at the end of the cycle → ACC.
- **ACC:** `ld_acc`=1, counter +1, pointer +1 modulo DEPTH.
  - If counter+1 == len → WR, else → RD.
- **WR:** `chip_en`=1, `wen`=1, `waddr`=dest. Accumulator output is the write data (datapath wiring) → DONE.
- **DONE:** `done`=1 → IDLE.

Rules and boundary conditions:
- **len clamping:** captured len > DEPTH is clamped to DEPTH.
- **Address wrap:** `raddr` wraps modulo DEPTH, e.g. base=14, len=4 reads 14, 15, 0, 1.
- **Read/write exclusion:** `ren` and `wen` are never both 1. `chip_en` is 1 only in RD and WR.
- **start while busy:** ignored; no queueing. `start` held high in DONE is not seen until IDLE.
- **Input stability:** `len`/`base_addr`/`dest_addr` changes after capture have no effect on the current operation.
- **dest overlapping the read range:** allowed. The write happens after all reads complete.
- **Width rules:**
  - Counter is ADDR_WIDTH+1 bits.
  - `raddr`/`waddr` are idle at 0 outside RD/WR.
  - Arithmetic widths belong to the datapath, not to this block.

## Timing

- Reset: async assert forces IDLE immediately.
  - All outputs 0: busy, done, chip_en, ren, wen, raddr, waddr, ld_coef, clr_acc, ld_prod, ld_acc.
  - Counter and captured values are 0.
- Reset mid-operation aborts with no write-back. Release is synchronous to the next clk edge.
- Cycle numbering: `start` high in IDLE in cycle 0.
  - CLEAR: cycle 1.
  - Element i: RD at 2+3i, MUL at 3+3i, ACC at 4+3i.
  - WR: cycle 2+3N.
  - DONE: cycle 3+3N.
  - IDLE: cycle 4+3N; a new start is accepted there.
- `busy` is high in cycles 1..3+3N.
- len=0: CLEAR at cycle 1, DONE at cycle 2, `busy` for 2 cycles.
- Back-to-back: minimum spacing between accepted starts is 3N+4 cycles.

## Test plan

- Reset: assert `rst`=0 mid-MUL of a len=4 run → all outputs 0 immediately. After release, no `wen` ever occurs and IDLE is held until the next start.
- Basic run: SRAM[0..3]={1,2,3,4}, coef=5, base=0, len=4, dest=8.
  - RD addresses 0,1,2,3 at cycles 2,5,8,11.
  - `wen` at cycle 14 with waddr=8; SRAM[8]=50.
  - `done` at cycle 15; `busy` for cycles 1..15.
- Wrap: base=14, len=4 → raddr sequence 14,15,0,1, then a single write at dest.
- len=0 and len=17: len=0 gives `done` at cycle 2 with no `chip_en`. len=17 is clamped to 16 reads with `done` at cycle 51.
- start during busy: pulse `start` at cycle 6 with different base/len → ignored. The original run's addresses and `done` timing are unchanged.
- Back-to-back: `start` held continuously → the second run's CLEAR occurs at cycle 3N+5 (start sampled in IDLE at 3N+4).
  - `ren`/`wen` are never simultaneously high across both runs.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: control sequencer for the SRAM / multiplier / adder
// multiply-accumulate datapath. A start request loads the coefficient,
// clears the accumulator, then walks len SRAM words (read, multiply,
// accumulate per element) and finally writes the sum back to dest.
module mac_seq_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,        // asynchronous, active-low
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] dest_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  chip_en,
  output logic                  ren,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  ld_coef,
  output logic                  clr_acc,
  output logic                  ld_prod,
  output logic                  ld_acc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RD,
    S_MUL,
    S_ACC,
    S_WR,
    S_DONE
  } state_e;

  // Largest element count a single operation may walk.
  localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH + 1)'(DEPTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q,   cnt_d;
  logic [ADDR_WIDTH:0]   len_q,   len_d;
  logic [ADDR_WIDTH-1:0] base_q,  base_d;
  logic [ADDR_WIDTH-1:0] dest_q,  dest_d;
  logic [ADDR_WIDTH-1:0] ptr_q,   ptr_d;
  logic [ADDR_WIDTH:0]   cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  // State and operand registers; reset aborts any operation in flight.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      base_q  <= '0;
      dest_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      base_q  <= base_d;
      dest_q  <= dest_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic: capture on start, walk the elements, then write back.
  // NOTE: every variable gets a hold default before the case so no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    base_d  = base_q;
    dest_d  = dest_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = (len > MAX_LEN) ? MAX_LEN : len;
          base_d  = base_addr;
          dest_d  = dest_addr;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        ptr_d   = base_q;
        state_d = (len_q == '0) ? S_DONE : S_RD;
      end
      S_RD:  state_d = S_MUL;
      S_MUL: state_d = S_ACC;
      S_ACC: begin
        cnt_d   = cnt_inc;
        ptr_d   = ptr_q + 1'b1;  // wraps modulo DEPTH by width
        state_d = (cnt_inc == len_q) ? S_WR : S_RD;
      end
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode from state, read pointer and captured destination.
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = 1'b0;
    chip_en = 1'b0;
    ren     = 1'b0;
    wen     = 1'b0;
    raddr   = '0;
    waddr   = '0;
    ld_coef = 1'b0;
    clr_acc = 1'b0;
    ld_prod = 1'b0;
    ld_acc  = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        ld_coef = 1'b1;
        clr_acc = 1'b1;
      end
      S_RD: begin
        chip_en = 1'b1;
        ren     = 1'b1;
        raddr   = ptr_q;
      end
      S_MUL: ld_prod = 1'b1;
      S_ACC: ld_acc  = 1'b1;
      S_WR: begin
        chip_en = 1'b1;
        wen     = 1'b1;
        waddr   = dest_q;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
